// File: rtl/fetch_if.sv
// fetch_if: handshake/bus bundle between the fetch stage and the rest of the core
//  master (fetch stage): in stall, redirect, redirect_pc, halt, imem_data
//                        out imem_addr, ifid_pc, ifid_instr, ifid_valid, halted, fetch_count
//  slave (core / bench): the mirror image of master
interface fetch_if #(
  parameter int PC_W = 9
);
  logic            stall;
  logic            redirect;
  logic [PC_W-1:0] redirect_pc;
  logic            halt;
  logic [PC_W-1:0] imem_addr;
  logic [31:0]     imem_data;
  logic [PC_W-1:0] ifid_pc;
  logic [31:0]     ifid_instr;
  logic            ifid_valid;
  logic            halted;
  logic [31:0]     fetch_count;
  modport master (
    input  stall, redirect, redirect_pc, halt, imem_data,
    output imem_addr, ifid_pc, ifid_instr, ifid_valid, halted, fetch_count
  );
  modport slave (
    output stall, redirect, redirect_pc, halt, imem_data,
    input  imem_addr, ifid_pc, ifid_instr, ifid_valid, halted, fetch_count
  );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: RV32I IF stage + IF/ID register with stall, redirect and HALT drain sequencer
//  clk, reset (sync, active-high); bus (fetch_if.master):
//  stall/redirect/redirect_pc/halt from hazard unit, EX and decode; imem_addr = pc (combinational);
//  imem_data same-cycle ROM data; ifid_pc/ifid_instr/ifid_valid IF/ID register;
//  halted parks the core; fetch_count saturating count of valid IF/ID loads
module fetch_stage #(
  parameter int          PC_W         = 9,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int          DRAIN_CYCLES = 3
) (
  input logic    clk,
  input logic    reset,
  fetch_if.master bus
);
  localparam int CW = DRAIN_CYCLES > 2 ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [31:0] NOP = 32'h0000_0013;
  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;
  state_t          state;
  logic [CW-1:0]   cnt;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] ifid_pc;
  logic [31:0]     ifid_instr;
  logic            ifid_valid;
  logic            halted;
  logic [31:0]     fetch_count;
  assign bus.imem_addr   = pc;
  assign bus.ifid_pc     = ifid_pc;
  assign bus.ifid_instr  = ifid_instr;
  assign bus.ifid_valid  = ifid_valid;
  assign bus.halted      = halted;
  assign bus.fetch_count = fetch_count;
  always_ff @(posedge clk)
    if (reset) begin
      state       <= RUN;
      cnt         <= '0;
      pc          <= RESET_PC;
      ifid_pc     <= '0;
      ifid_instr  <= NOP;
      ifid_valid  <= 1'b0;
      halted      <= 1'b0;
      fetch_count <= '0;
    end else begin
      case (state)
        RUN:
          if (bus.redirect) begin
            pc         <= {bus.redirect_pc[PC_W-1:2], 2'b00};
            ifid_instr <= NOP;
            ifid_valid <= 1'b0;
          end else if (bus.halt && ifid_valid && !bus.stall) begin
            ifid_instr <= NOP;
            ifid_valid <= 1'b0;
            cnt        <= CW'(DRAIN_CYCLES - 1);
            state      <= DRAIN;
          end else if (!bus.stall) begin
            ifid_pc     <= pc;
            ifid_instr  <= bus.imem_data;
            ifid_valid  <= 1'b1;
            pc          <= pc + PC_W'(4);
            fetch_count <= (fetch_count == '1) ? fetch_count : fetch_count + 32'd1;
          end
        DRAIN: begin
          ifid_instr <= NOP;
          ifid_valid <= 1'b0;
          cnt        <= (cnt == '0) ? cnt : cnt - CW'(1);
          state      <= (cnt == '0) ? HALTED : DRAIN;
          halted     <= (cnt == '0);
        end
        HALTED: halted <= 1'b1;
        default: state <= RUN;
      endcase
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed checks of fetch_stage reset, stall, redirect, halt drain and wrap
module tb_fetch_stage;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int fails = 0;
  fetch_if #(.PC_W(9)) bus ();
  fetch_stage #(.PC_W(9), .RESET_PC(9'h000), .DRAIN_CYCLES(3)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.master)
  );
  always #5 clk = ~clk;
  assign bus.imem_data = (bus.imem_addr == 9'h000) ? 32'h0050_0093 : (32'hA500_0000 | {23'b0, bus.imem_addr});
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    reset = 1'b1;
    bus.stall = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_pc = '0;
    bus.halt = 1'b0;
    tick();
    tick();
    checks++;
    if ({bus.imem_addr, bus.ifid_pc, bus.ifid_valid, bus.halted} !== {9'h000, 9'h000, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL reset_state got pc=%h ifid_pc=%h v=%b h=%b want 000 000 0 0", bus.imem_addr, bus.ifid_pc, bus.ifid_valid, bus.halted);
    end
    checks++;
    if (bus.ifid_instr !== 32'h0000_0013) begin
      fails++;
      $display("FAIL reset_instr got %h want 00000013", bus.ifid_instr);
    end
    checks++;
    if (bus.fetch_count !== 32'd0) begin
      fails++;
      $display("FAIL reset_count got %0d want 0", bus.fetch_count);
    end
    reset = 1'b0;
    tick();
    checks++;
    if ({bus.imem_addr, bus.ifid_pc, bus.ifid_valid, bus.halted} !== {9'h004, 9'h000, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL first_fetch got pc=%h ifid_pc=%h v=%b h=%b want 004 000 1 0", bus.imem_addr, bus.ifid_pc, bus.ifid_valid, bus.halted);
    end
    checks++;
    if (bus.ifid_instr !== 32'h0050_0093) begin
      fails++;
      $display("FAIL first_instr got %h want 00500093", bus.ifid_instr);
    end
    checks++;
    if (bus.fetch_count !== 32'd1) begin
      fails++;
      $display("FAIL first_count got %0d want 1", bus.fetch_count);
    end
  endtask
  task automatic test_stall();
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if ({bus.imem_addr, bus.ifid_pc, bus.ifid_valid, bus.ifid_instr, bus.fetch_count} !== {9'h014, 9'h010, 1'b1, 32'hA500_0010, 32'd5}) begin
      fails++;
      $display("FAIL straight_line got pc=%h ifid_pc=%h v=%b instr=%h cnt=%0d want 014 010 1 a5000010 5", bus.imem_addr, bus.ifid_pc, bus.ifid_valid, bus.ifid_instr, bus.fetch_count);
    end
    bus.stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({bus.imem_addr, bus.ifid_pc, bus.ifid_valid, bus.ifid_instr, bus.fetch_count} !== {9'h014, 9'h010, 1'b1, 32'hA500_0010, 32'd5}) begin
        fails++;
        $display("FAIL stall_hold%0d got pc=%h ifid_pc=%h v=%b instr=%h cnt=%0d want 014 010 1 a5000010 5", i, bus.imem_addr, bus.ifid_pc, bus.ifid_valid, bus.ifid_instr, bus.fetch_count);
      end
    end
    bus.stall = 1'b0;
    tick();
    checks++;
    if ({bus.imem_addr, bus.ifid_pc, bus.ifid_valid, bus.ifid_instr, bus.fetch_count} !== {9'h018, 9'h014, 1'b1, 32'hA500_0014, 32'd6}) begin
      fails++;
      $display("FAIL stall_resume got pc=%h ifid_pc=%h v=%b instr=%h cnt=%0d want 018 014 1 a5000014 6", bus.imem_addr, bus.ifid_pc, bus.ifid_valid, bus.ifid_instr, bus.fetch_count);
    end
  endtask
  task automatic test_redirect();
    bus.redirect = 1'b1;
    bus.redirect_pc = 9'h041;
    bus.stall = 1'b1;
    tick();
    checks++;
    if ({bus.imem_addr, bus.ifid_valid, bus.ifid_instr, bus.fetch_count} !== {9'h040, 1'b0, 32'h0000_0013, 32'd6}) begin
      fails++;
      $display("FAIL redirect_bubble got pc=%h v=%b instr=%h cnt=%0d want 040 0 00000013 6", bus.imem_addr, bus.ifid_valid, bus.ifid_instr, bus.fetch_count);
    end
    bus.redirect = 1'b0;
    bus.stall = 1'b0;
    tick();
    checks++;
    if ({bus.imem_addr, bus.ifid_pc, bus.ifid_valid, bus.ifid_instr, bus.fetch_count} !== {9'h044, 9'h040, 1'b1, 32'hA500_0040, 32'd7}) begin
      fails++;
      $display("FAIL redirect_target got pc=%h ifid_pc=%h v=%b instr=%h cnt=%0d want 044 040 1 a5000040 7", bus.imem_addr, bus.ifid_pc, bus.ifid_valid, bus.ifid_instr, bus.fetch_count);
    end
  endtask
  task automatic test_halt_vs_redirect();
    bus.halt = 1'b1;
    bus.redirect = 1'b1;
    bus.redirect_pc = 9'h080;
    tick();
    checks++;
    if ({bus.imem_addr, bus.ifid_valid, bus.halted} !== {9'h080, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL halt_redirect got pc=%h v=%b h=%b want 080 0 0", bus.imem_addr, bus.ifid_valid, bus.halted);
    end
    bus.redirect = 1'b0;
    tick();
    checks++;
    if ({bus.imem_addr, bus.ifid_pc, bus.ifid_valid, bus.halted, bus.fetch_count} !== {9'h084, 9'h080, 1'b1, 1'b0, 32'd8}) begin
      fails++;
      $display("FAIL halt_on_bubble got pc=%h ifid_pc=%h v=%b h=%b cnt=%0d want 084 080 1 0 8", bus.imem_addr, bus.ifid_pc, bus.ifid_valid, bus.halted, bus.fetch_count);
    end
    bus.stall = 1'b1;
    tick();
    checks++;
    if ({bus.imem_addr, bus.ifid_pc, bus.ifid_valid, bus.halted, bus.fetch_count} !== {9'h084, 9'h080, 1'b1, 1'b0, 32'd8}) begin
      fails++;
      $display("FAIL halt_under_stall got pc=%h ifid_pc=%h v=%b h=%b cnt=%0d want 084 080 1 0 8", bus.imem_addr, bus.ifid_pc, bus.ifid_valid, bus.halted, bus.fetch_count);
    end
    bus.stall = 1'b0;
    bus.halt = 1'b0;
  endtask
  task automatic test_halt();
    bus.halt = 1'b1;
    tick();
    checks++;
    if ({bus.imem_addr, bus.ifid_valid, bus.halted, bus.fetch_count} !== {9'h084, 1'b0, 1'b0, 32'd8}) begin
      fails++;
      $display("FAIL halt_accept got pc=%h v=%b h=%b cnt=%0d want 084 0 0 8", bus.imem_addr, bus.ifid_valid, bus.halted, bus.fetch_count);
    end
    bus.halt = 1'b0;
    bus.redirect = 1'b1;
    bus.redirect_pc = 9'h100;
    bus.stall = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++;
      if ({bus.imem_addr, bus.ifid_valid, bus.halted} !== {9'h084, 1'b0, i == 3}) begin
        fails++;
        $display("FAIL drain_edge%0d got pc=%h v=%b h=%b want 084 0 %0d", i, bus.imem_addr, bus.ifid_valid, bus.halted, i == 3);
      end
    end
    bus.redirect = 1'b0;
    bus.stall = 1'b0;
    bus.halt = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({bus.imem_addr, bus.ifid_valid, bus.halted, bus.fetch_count} !== {9'h084, 1'b0, 1'b1, 32'd8}) begin
        fails++;
        $display("FAIL halted_frozen%0d got pc=%h v=%b h=%b cnt=%0d want 084 0 1 8", i, bus.imem_addr, bus.ifid_valid, bus.halted, bus.fetch_count);
      end
    end
    bus.halt = 1'b0;
    reset = 1'b1;
    tick();
    checks++;
    if ({bus.imem_addr, bus.ifid_valid, bus.halted, bus.fetch_count} !== {9'h000, 1'b0, 1'b0, 32'd0}) begin
      fails++;
      $display("FAIL halted_reset got pc=%h v=%b h=%b cnt=%0d want 000 0 0 0", bus.imem_addr, bus.ifid_valid, bus.halted, bus.fetch_count);
    end
    reset = 1'b0;
  endtask
  task automatic test_wrap_and_drain_reset();
    bus.redirect = 1'b1;
    bus.redirect_pc = 9'h1FC;
    tick();
    checks++;
    if ({bus.imem_addr, bus.ifid_valid, bus.fetch_count} !== {9'h1FC, 1'b0, 32'd0}) begin
      fails++;
      $display("FAIL wrap_redirect got pc=%h v=%b cnt=%0d want 1fc 0 0", bus.imem_addr, bus.ifid_valid, bus.fetch_count);
    end
    bus.redirect = 1'b0;
    tick();
    checks++;
    if ({bus.imem_addr, bus.ifid_pc, bus.ifid_valid, bus.ifid_instr, bus.fetch_count} !== {9'h000, 9'h1FC, 1'b1, 32'hA500_01FC, 32'd1}) begin
      fails++;
      $display("FAIL pc_wrap got pc=%h ifid_pc=%h v=%b instr=%h cnt=%0d want 000 1fc 1 a50001fc 1", bus.imem_addr, bus.ifid_pc, bus.ifid_valid, bus.ifid_instr, bus.fetch_count);
    end
    bus.halt = 1'b1;
    tick();
    bus.halt = 1'b0;
    tick();
    checks++;
    if ({bus.imem_addr, bus.ifid_valid, bus.halted} !== {9'h000, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL in_drain got pc=%h v=%b h=%b want 000 0 0", bus.imem_addr, bus.ifid_valid, bus.halted);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    checks++;
    if ({bus.imem_addr, bus.ifid_pc, bus.ifid_valid, bus.halted, bus.fetch_count} !== {9'h004, 9'h000, 1'b1, 1'b0, 32'd1}) begin
      fails++;
      $display("FAIL drain_reset got pc=%h ifid_pc=%h v=%b h=%b cnt=%0d want 004 000 1 0 1", bus.imem_addr, bus.ifid_pc, bus.ifid_valid, bus.halted, bus.fetch_count);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({bus.imem_addr, bus.ifid_valid, bus.halted} !== {9'(8 + 4 * i), 1'b1, 1'b0}) begin
        fails++;
        $display("FAIL post_reset_run%0d got pc=%h v=%b h=%b want %h 1 0", i, bus.imem_addr, bus.ifid_valid, bus.halted, 9'(8 + 4 * i));
      end
    end
  endtask
  initial begin
    test_reset();
    test_stall();
    test_redirect();
    test_halt_vs_redirect();
    test_halt();
    test_wrap_and_drain_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
    $finish;
  end
endmodule
